// File: rtl/bcd_scan_pkg.sv
// Shared constants for the bcd_scan7seg display driver: segment codes, default sizing and width helper.
package bcd_scan_pkg;

  // Segment codes, bit 0 = a ... bit 6 = g, active-high
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  // Counter width able to hold 0..n-1, never narrower than one bit
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned NDIG_DEF     = 4;
  localparam int unsigned PRESCALE_DEF = 1000;
  localparam int unsigned BLANK_DEF    = 2;
  localparam int unsigned PRE_W_DEF    = cnt_w(PRESCALE_DEF);
  localparam int unsigned IDX_W_DEF    = cnt_w(NDIG_DEF);

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to 7-segment decoder; codes A..F show a dash.
module bcd_to_7seg
  import bcd_scan_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = SEG_DASH;
    case (bcd)
      4'd0:    seg_c = SEG_0;
      4'd1:    seg_c = SEG_1;
      4'd2:    seg_c = SEG_2;
      4'd3:    seg_c = SEG_3;
      4'd4:    seg_c = SEG_4;
      4'd5:    seg_c = SEG_5;
      4'd6:    seg_c = SEG_6;
      4'd7:    seg_c = SEG_7;
      4'd8:    seg_c = SEG_8;
      4'd9:    seg_c = SEG_9;
      default: seg_c = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_scan7seg.sv
// Multiplexed 7-segment scan driver for NDIG BCD digits with shadow capture and anti-ghost blanking.
// Optional leading-zero blanking is enabled by defining BCD_SCAN_LZB_EN.
module bcd_scan7seg
  import bcd_scan_pkg::*;
#(
  parameter int unsigned NDIG         = NDIG_DEF,
  parameter int unsigned PRESCALE     = PRESCALE_DEF,
  parameter int unsigned BLANK_CYCLES = BLANK_DEF
) (
  input  logic              CLK,
  input  logic              CDN,
  input  logic              EN,
  input  logic              LATCH,
  input  logic [4*NDIG-1:0] DIG,
  input  logic [NDIG-1:0]   DPI,
  output logic [6:0]        SEG,
  output logic              DP,
  output logic [NDIG-1:0]   AN,
  output logic              FRAME
);

  localparam int unsigned PRE_W = cnt_w(PRESCALE);
  localparam int unsigned IDX_W = cnt_w(NDIG);

  logic [PRE_W-1:0]  pre, pre_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [4*NDIG-1:0] dig_sh;
  logic [NDIG-1:0]   dpi_sh;

  logic              slot_end, wrap, strobe, lead_blank, cur_dp;
  logic [3:0]        cur_digit;
  logic [6:0]        seg_dec_c;
  logic [6:0]        seg_nxt;
  logic              dp_nxt, frame_nxt;
  logic [NDIG-1:0]   an_nxt;

  // Slot prescaler and digit index
  always_comb begin
    slot_end = (pre == PRE_W'(PRESCALE - 1));
    wrap     = slot_end && (idx == IDX_W'(NDIG - 1));
    pre_nxt  = pre;
    idx_nxt  = idx;
    if (EN) begin
      if (slot_end) begin
        pre_nxt = '0;
        idx_nxt = wrap ? '0 : idx + IDX_W'(1);
      end else begin
        pre_nxt = pre + PRE_W'(1);
      end
    end
  end

  // Select the shadow digit being scanned
  always_comb begin
    cur_digit = 4'd0;
    cur_dp    = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_digit = dig_sh[4*i +: 4];
        cur_dp    = dpi_sh[i];
      end
    end
  end

`ifdef BCD_SCAN_LZB_EN
  // Blank digit idx>0 when it and every more significant digit are zero
  always_comb begin
    lead_blank = (idx != '0);
    for (int i = 0; i < NDIG; i++) begin
      if ((IDX_W'(i) >= idx) && (dig_sh[4*i +: 4] != 4'd0)) lead_blank = 1'b0;
    end
  end
`else
  assign lead_blank = 1'b0;
`endif

  bcd_to_7seg u_dec (
    .bcd   (cur_digit),
    .seg_c (seg_dec_c)
  );

  // Next output values; strobes stay dark during the anti-ghost window
  always_comb begin
    strobe    = EN && (pre >= PRE_W'(BLANK_CYCLES));
    an_nxt    = '1;
    seg_nxt   = SEG_OFF;
    dp_nxt    = 1'b0;
    frame_nxt = EN && wrap;
    if (strobe) begin
      an_nxt  = ~(NDIG'(1) << idx);
      seg_nxt = lead_blank ? SEG_OFF : seg_dec_c;
      dp_nxt  = cur_dp;
    end
  end

  always_ff @(posedge CLK or negedge CDN) begin
    if (!CDN) begin
      pre    <= '0;
      idx    <= '0;
      dig_sh <= '0;
      dpi_sh <= '0;
      AN     <= '1;
      SEG    <= SEG_OFF;
      DP     <= 1'b0;
      FRAME  <= 1'b0;
    end else begin
      pre   <= pre_nxt;
      idx   <= idx_nxt;
      AN    <= an_nxt;
      SEG   <= seg_nxt;
      DP    <= dp_nxt;
      FRAME <= frame_nxt;
      if (LATCH) begin
        dig_sh <= DIG;
        dpi_sh <= DPI;
      end
    end
  end

endmodule

// File: tb/tb_bcd_scan7seg.sv
// Self-checking bench for bcd_scan7seg (NDIG=4, PRESCALE=4, BLANK_CYCLES=1); honours BCD_SCAN_LZB_EN.
module tb_bcd_scan7seg;

  logic        CLK = 1'b0;
  logic        CDN = 1'b0;
  logic        EN = 1'b0;
  logic        LATCH = 1'b0;
  logic [15:0] DIG = '0;
  logic [3:0]  DPI = '0;
  logic [6:0]  SEG;
  logic        DP;
  logic [3:0]  AN;
  logic        FRAME;

  int checks = 0;
  int passed = 0;

  logic [12:0] sb_q[$];

  int          m_pre = 0;
  int          m_idx = 0;
  logic [15:0] m_dig = '0;
  logic [3:0]  m_dpi = '0;

  bcd_scan7seg #(.NDIG(4), .PRESCALE(4), .BLANK_CYCLES(1)) dut (
    .CLK   (CLK),
    .CDN   (CDN),
    .EN    (EN),
    .LATCH (LATCH),
    .DIG   (DIG),
    .DPI   (DPI),
    .SEG   (SEG),
    .DP    (DP),
    .AN    (AN),
    .FRAME (FRAME)
  );

  always #5 CLK = ~CLK;

  function automatic logic [6:0] ref_dec(input logic [3:0] v);
    case (v)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  // One clock: push the expected output for this edge, advance the model, then compare
  task automatic cyc();
    logic [3:0]  an;
    logic [6:0]  sg;
    logic        dp, fr;
    logic [12:0] exp_v, obs_v;
`ifdef BCD_SCAN_LZB_EN
    logic        blank;
`endif
    an = 4'hF; sg = 7'h00; dp = 1'b0;
    fr = EN && (m_pre == 3) && (m_idx == 3);
    if (EN && (m_pre >= 1)) begin
      an[m_idx] = 1'b0;
      sg = ref_dec(m_dig[m_idx*4 +: 4]);
      dp = m_dpi[m_idx];
`ifdef BCD_SCAN_LZB_EN
      blank = (m_idx > 0);
      for (int j = m_idx; j < 4; j++) if (m_dig[j*4 +: 4] != 4'd0) blank = 1'b0;
      if (blank) sg = 7'h00;
`endif
    end
    sb_q.push_back({an, sg, dp, fr});
    if (LATCH) begin
      m_dig = DIG;
      m_dpi = DPI;
    end
    if (EN) begin
      if (m_pre == 3) begin
        m_pre = 0;
        m_idx = (m_idx + 1) % 4;
      end else begin
        m_pre = m_pre + 1;
      end
    end
    @(posedge CLK);
    #1;
    exp_v = sb_q.pop_front();
    obs_v = {AN, SEG, DP, FRAME};
    checks++;
    if (obs_v !== exp_v)
      $display("FAIL sb t=%0t AN/SEG/DP/FRAME got %h/%h/%b/%b want %h/%h/%b/%b", $time,
               obs_v[12:9], obs_v[8:2], obs_v[1], obs_v[0], exp_v[12:9], exp_v[8:2], exp_v[1], exp_v[0]);
    else passed++;
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #1;
    CDN = 1'b0;
    #2;
    CDN = 1'b1;
    m_pre = 0; m_idx = 0; m_dig = '0; m_dpi = '0;
  endtask

  task automatic test_reset();
    CDN = 1'b0; EN = 1'b1; LATCH = 1'b1; DIG = 16'h9999; DPI = 4'hF;
    repeat (3) begin
      @(posedge CLK);
      #1;
      checks++;
      if ({AN, SEG, DP, FRAME} !== {4'hF, 7'h00, 1'b0, 1'b0})
        $display("FAIL reset AN=%h SEG=%h DP=%b FRAME=%b want F/00/0/0", AN, SEG, DP, FRAME);
      else passed++;
    end
    LATCH = 1'b0;
    #2;
    CDN = 1'b1;
    m_pre = 0; m_idx = 0; m_dig = '0; m_dpi = '0;
  endtask

  task automatic test_scan();
    logic [11:0] want;
    int frames;
    do_reset();
    EN = 1'b0; LATCH = 1'b1; DIG = 16'h4321; DPI = 4'b0010;
    cyc();
    EN = 1'b1; LATCH = 1'b0;
    frames = 0;
    for (int k = 0; k < 32; k++) begin
      cyc();
      if (FRAME) frames++;
      if ((k % 4) <= 1) begin
        case (k % 16)
          1:       want = {4'b1110, 7'h06, 1'b0};
          5:       want = {4'b1101, 7'h5B, 1'b1};
          9:       want = {4'b1011, 7'h4F, 1'b0};
          13:      want = {4'b0111, 7'h66, 1'b0};
          default: want = {4'b1111, 7'h00, 1'b0};
        endcase
        checks++;
        if ({AN, SEG, DP} !== want)
          $display("FAIL scan k=%0d AN/SEG/DP got %b/%h/%b want %b/%h/%b", k, AN, SEG, DP,
                   want[11:8], want[7:1], want[0]);
        else passed++;
      end
    end
    checks++;
    if (frames !== 2) $display("FAIL frame_count got %0d want 2", frames);
    else passed++;
  endtask

  task automatic test_decode();
    logic [3:0] vals [11];
    vals = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'hC};
    foreach (vals[n]) begin
      do_reset();
      EN = 1'b1; LATCH = 1'b1; DIG = {12'h000, vals[n]}; DPI = 4'b0000;
      cyc();
      LATCH = 1'b0;
      cyc();
      checks++;
      if (SEG !== ref_dec(vals[n]))
        $display("FAIL decode v=%h got %h want %h", vals[n], SEG, ref_dec(vals[n]));
      else passed++;
    end
  endtask

  task automatic test_latch();
    int p, i;
    do_reset();
    EN = 1'b1; LATCH = 1'b1; DIG = 16'h1234; DPI = 4'b0000;
    cyc();
    LATCH = 1'b0; DIG = 16'h5678;
    for (int k = 0; k < 16; k++) begin
      p = m_pre; i = m_idx;
      cyc();
      if (i == 0 && p == 1) begin
        checks++;
        if (SEG !== 7'h66) $display("FAIL latch_hold got %h want 66", SEG);
        else passed++;
      end
    end
    while (!(m_pre == 3 && m_idx == 3)) cyc();
    LATCH = 1'b1;
    cyc();
    LATCH = 1'b0;
    cyc();
    cyc();
    checks++;
    if ({AN, SEG} !== {4'b1110, 7'h7F}) $display("FAIL latch_new AN/SEG got %b/%h want 1110/7f", AN, SEG);
    else passed++;
  endtask

  task automatic test_enable();
    logic [3:0] a;
    while (m_pre != 2) cyc();
    a = 4'hF;
    a[m_idx] = 1'b0;
    EN = 1'b0;
    cyc();
    checks++;
    if ({AN, SEG, DP} !== {4'hF, 7'h00, 1'b0}) $display("FAIL en_off got %b/%h/%b want 1111/00/0", AN, SEG, DP);
    else passed++;
    repeat (4) cyc();
    EN = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      checks++;
      if (AN !== ((k < 2) ? a : 4'hF))
        $display("FAIL en_resume k=%0d AN got %b want %b", k, AN, (k < 2) ? a : 4'hF);
      else passed++;
    end
  endtask

  task automatic test_lzb();
    logic [15:0] pats [2];
    logic [6:0]  want;
    logic [3:0]  a;
    int p, i;
    pats = '{16'h0030, 16'h0000};
    foreach (pats[n]) begin
      do_reset();
      EN = 1'b1; LATCH = 1'b1; DIG = pats[n]; DPI = 4'b0000;
      cyc();
      LATCH = 1'b0;
      for (int k = 0; k < 16; k++) begin
        p = m_pre; i = m_idx;
        cyc();
        if (p == 2) begin
          want = (n == 0 && i == 1) ? 7'h4F : 7'h3F;
`ifdef BCD_SCAN_LZB_EN
          if (n == 0 && i >= 2) want = 7'h00;
          if (n == 1 && i >= 1) want = 7'h00;
`endif
          a = 4'hF;
          a[i] = 1'b0;
          checks++;
          if ({AN, SEG} !== {a, want})
            $display("FAIL lzb pat=%h dig=%0d AN/SEG got %b/%h want %b/%h", pats[n], i, AN, SEG, a, want);
          else passed++;
        end
      end
    end
  endtask

  task automatic test_async_clear();
    do_reset();
    EN = 1'b1; LATCH = 1'b1; DIG = 16'h4321; DPI = 4'b1111;
    cyc();
    LATCH = 1'b0;
    while (!(m_pre == 3 && m_idx == 1)) cyc();
    #2;
    CDN = 1'b0;
    #1;
    checks++;
    if ({AN, SEG, DP, FRAME} !== {4'hF, 7'h00, 1'b0, 1'b0})
      $display("FAIL async_clear AN/SEG/DP/FRAME got %b/%h/%b/%b want 1111/00/0/0", AN, SEG, DP, FRAME);
    else passed++;
    @(negedge CLK);
    CDN = 1'b1;
    m_pre = 0; m_idx = 0; m_dig = '0; m_dpi = '0;
    repeat (4) cyc();
  endtask

  initial begin
    test_reset();
    test_scan();
    test_decode();
    test_latch();
    test_enable();
    test_lzb();
    test_async_clear();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
